booth_mult_seq: RTL
===================

// Module: booth_mult_seq
// PURPOSE
//  Sequential, parametrised signed Booth multiplier; successor to the unrolled 8x8 combinational array.
//  Reuses one add/sub datapath for WIDTH iterations (radix-2) instead of WIDTH cascaded stages.
//  Valid/ready handshakes on operand and product sides; sits between arithmetic pipeline stages.
// PARAMETERS
//  WIDTH   8   operand width in bits (two's complement); >=2; must be even when radix-4 is compiled in
// PORTS
//  clk        in   1        clock, rising-edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        operand pair a/b valid
//  in_ready   out  1        block can accept operands this cycle
//  a          in   WIDTH    multiplier (signed), sampled on accept
//  b          in   WIDTH    multiplicand (signed), sampled on accept
//  out_valid  out  1        product valid
//  out_ready  in   1        consumer takes product this cycle
//  product    out  2*WIDTH  signed a*b, held stable while out_valid=1
//  busy       out  1        1 while state==RUN
// BEHAVIOUR
//  Reset (async assert, any state): state=IDLE, out_valid=0, product=0, busy=0, counter=0, accumulator=0.
//  FSM states IDLE, RUN, DONE:
//   IDLE: in_ready=1. in_valid=1 -> accept: ACC=0, Q=a, q_1=0, M=sext(b), cnt=0 -> RUN.
//   RUN : one Booth step per edge; cnt++; after step NSTEP-1 -> DONE, product<=ACC:Q (low 2*WIDTH).
//   DONE: out_valid=1; product stable. out_ready=1 -> leave DONE (to IDLE, or RUN if new accept).
//  in_ready = (IDLE) | (DONE & out_ready): back-to-back accept on same edge as product handoff.
//  in_valid ignored while in_ready=0; a/b may change freely outside the accept edge.
//  Radix-2 step on {Q[0],q_1}: 00/11 none, 10 ACC-=M, 01 ACC+=M; then arithmetic right shift of {ACC,Q,q_1} by 1.
//  ACC width WIDTH+1 (radix-2) so M=-2^(WIDTH-1) never overflows; shift replicates ACC MSB.
//  NSTEP = WIDTH (radix-2). Latency: out_valid first high WIDTH edges after the accept edge.
//  Throughput with out_ready tied 1: one product per WIDTH+1 cycles (DONE cycle overlaps next accept).
//  out_ready high outside DONE: no effect. product retains last value in IDLE/RUN (not cleared).
//  Reset mid-RUN: computation discarded, no out_valid pulse afterwards.
// CONFIGURATION
//  BOOTH_RADIX4_EN defined: radix-4 recoding on {Q[1],Q[0],q_1} -> {0,+M,+M,+2M,-2M,-M,-M,0};
//   ACC width WIDTH+2; shift by 2 per step; NSTEP=WIDTH/2; latency WIDTH/2; elaboration error if WIDTH odd.
//  Undefined: radix-2 only as above. Ports, handshake and product values identical in both builds.
// STRUCTURE
//  Package booth_pkg: state enum (IDLE/RUN/DONE), Booth op enum (NONE/ADD1/SUB1/ADD2/SUB2),
//   recode function (bits -> op), step-count localparam helper.
//  Sub-module booth_step: combinational recode + add/sub + arithmetic shift of {ACC,Q,q_1};
//   parametrised on WIDTH and radix; top holds FSM, counter, registers, handshake.
// TESTING
//  1) WIDTH=8: a=3,b=-5, out_ready=1 -> product=16'hFFF1 (-15), out_valid high 8 edges after accept.
//  2) a=-128,b=-128 -> product=16'h4000; a=-128,b=127 -> 16'hC080 (no ACC overflow).
//  3) out_ready=0 for 10 cycles in DONE -> product, out_valid stable; in_ready=0; then one-cycle handoff.
//  4) Back-to-back: in_valid held 1 with 3 operand pairs, out_ready=1 -> accepts on DONE edges, 3 correct products, period 9 cycles.
//  5) rst asserted mid-RUN (cnt=4) asynchronously -> out_valid=0,product=0,in_ready=1 immediately; next op correct.
//  6) Random signed sweep, WIDTH=8 and 16, both with/without BOOTH_RADIX4_EN -> product==a*b; radix-4 latency WIDTH/2.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential Booth multiplier.
// BOOTH_RADIX4_EN selects radix-4 recoding; default build is radix-2.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        NONE,
        ADD1,
        SUB1,
        ADD2,
        SUB2
    } booth_op_t;

`ifdef BOOTH_RADIX4_EN
    localparam int RADIX4 = 1;
`else
    localparam int RADIX4 = 0;
`endif

    // Radix-4 table; radix-2 feeds {q0,q0,q_1} so only NONE/ADD1/SUB1 appear.
    function automatic booth_op_t recode(input logic [2:0] bits);
        booth_op_t op;
        case (bits)
            3'b001, 3'b010: op = ADD1;
            3'b011:         op = ADD2;
            3'b100:         op = SUB2;
            3'b101, 3'b110: op = SUB1;
            default:        op = NONE;
        endcase
        return op;
    endfunction

    function automatic int nstep(input int width, input int r4);
        return (r4 != 0) ? width / 2 : width;
    endfunction

endpackage

// File: rtl/booth_mult_seq_step.sv
// One Booth iteration: recode, add/sub multiplicand, arithmetic shift of {acc,q,q_1}.
// Radix chosen by R4 (driven from BOOTH_RADIX4_EN in the top).
import booth_pkg::*;

module booth_mult_seq_step #(
    parameter int WIDTH = 8,
    parameter int R4    = 0,
    parameter int AW    = WIDTH + 1 + R4
) (
    input  logic [AW-1:0]    acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [AW-1:0]    m,
    output logic [AW-1:0]    acc_n,
    output logic [WIDTH-1:0] q_n,
    output logic             q_1_n
);
    localparam int TW = AW + WIDTH + 1;
    localparam int SH = 1 + R4;

    logic [2:0]           bits;
    booth_op_t            op;
    logic [AW-1:0]        m2;
    logic [AW-1:0]        sum;
    logic signed [TW-1:0] cat;
    logic signed [TW-1:0] shifted;

    always_comb begin
        bits = (R4 != 0) ? {q[1], q[0], q_1} : {q[0], q[0], q_1};
        op   = recode(bits);
        m2   = {m[AW-2:0], 1'b0};
        case (op)
            ADD1:    sum = acc + m;
            SUB1:    sum = acc - m;
            ADD2:    sum = acc + m2;
            SUB2:    sum = acc - m2;
            default: sum = acc;
        endcase
        cat     = {sum, q, q_1};
        shifted = cat >>> SH;
        {acc_n, q_n, q_1_n} = shifted;
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier with valid/ready handshakes on both sides.
// Radix-4 recoding when BOOTH_RADIX4_EN is defined (WIDTH must then be even).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one Booth step per clock, busy=1
// DONE  | product presented with out_valid=1 until out_ready
import booth_pkg::*;

module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int NSTEP = nstep(WIDTH, RADIX4);
    localparam int AW    = WIDTH + 1 + RADIX4;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    if (RADIX4 != 0 && (WIDTH % 2) != 0) begin : g_width_chk
        $error("booth_mult_seq: WIDTH must be even for radix-4");
    end

    state_t           state, state_n;
    logic [AW-1:0]    acc, acc_n, m;
    logic [WIDTH-1:0] q, q_n;
    logic             q_1, q_1_n;
    logic [CW-1:0]    step_cnt;
    logic             accept;

    booth_mult_seq_step #(.WIDTH(WIDTH), .R4(RADIX4), .AW(AW)) u_step (
        .acc   (acc),
        .q     (q),
        .q_1   (q_1),
        .m     (m),
        .acc_n (acc_n),
        .q_n   (q_n),
        .q_1_n (q_1_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (step_cnt == '0) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready = 1'b1;
                    state_n  = in_valid ? RUN : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        accept = in_ready & in_valid;
    end

    // Step counter runs down from NSTEP-1; terminal count marks the final step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            q        <= '0;
            q_1      <= 1'b0;
            m        <= '0;
            step_cnt <= '0;
            product  <= '0;
        end else if (accept) begin
            acc      <= '0;
            q        <= a;
            q_1      <= 1'b0;
            m        <= {{(AW-WIDTH){b[WIDTH-1]}}, b};
            step_cnt <= CW'(NSTEP - 1);
        end else if (state == RUN) begin
            acc <= acc_n;
            q   <= q_n;
            q_1 <= q_1_n;
            if (step_cnt == '0) product  <= {acc_n[WIDTH-1:0], q_n};
            else                step_cnt <= step_cnt - 1'b1;
        end
    end

endmodule
